// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Op codes shared with the ALU control decoder, FSM state encoding
//            and default datapath widths for alu_exec_unit.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  localparam logic [3:0] c_OP_AND = 4'b0000;
  localparam logic [3:0] c_OP_ADD = 4'b0001;
  localparam logic [3:0] c_OP_SUB = 4'b0010;
  localparam logic [3:0] c_OP_OR  = 4'b0011;
  localparam logic [3:0] c_OP_SLL = 4'b0101;
  localparam logic [3:0] c_OP_SRL = 4'b0110;
  localparam logic [3:0] c_OP_SRA = 4'b1000;
  localparam logic [3:0] c_OP_SLT = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == c_OP_SLL) || (op == c_OP_SRL) || (op == c_OP_SRA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shifter.sv
`default_nettype none
// ============================================================================
// Module   : alu_shifter
// Brief    : Shift datapath. One-bit step by default; full barrel shift by
//            i_shamt when ALU_BARREL_SHIFT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF
`ifdef ALU_BARREL_SHIFT_EN
 ,parameter int SHAMT_W = SHAMT_W_DEF
`endif
) (
  input  logic [3:0]         i_op,
  input  logic [WIDTH-1:0]   i_data,
`ifdef ALU_BARREL_SHIFT_EN
  input  logic [SHAMT_W-1:0] i_shamt,
`endif
  output logic [WIDTH-1:0]   o_data
);

`ifdef ALU_BARREL_SHIFT_EN
  always_comb begin
    o_data = i_data;
    case (i_op)
      c_OP_SLL: o_data = i_data << i_shamt;
      c_OP_SRL: o_data = i_data >> i_shamt;
      c_OP_SRA: o_data = $signed(i_data) >>> i_shamt;
      default:  o_data = i_data;
    endcase
  end
`else
  always_comb begin
    o_data = i_data;
    case (i_op)
      c_OP_SLL: o_data = {i_data[WIDTH-2:0], 1'b0};
      c_OP_SRL: o_data = {1'b0, i_data[WIDTH-1:1]};
      c_OP_SRA: o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
      default:  o_data = i_data;
    endcase
  end
`endif

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : EX-stage ALU with valid/ready in and out; shifts are iterative
//            unless ALU_BARREL_SHIFT_EN is defined (single-cycle barrel).
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             IllegalOp
);

  alu_state_t          r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [WIDTH-1:0]    r_result;
  logic                r_zero;
  logic                r_ovf;
  logic                r_illegal;
`ifndef ALU_BARREL_SHIFT_EN
  logic [3:0]          r_op;
  logic [SHAMT_W-1:0]  r_cnt;
`endif

  logic [WIDTH-1:0]    w_sum;
  logic [WIDTH-1:0]    w_diff;
  logic [WIDTH-1:0]    w_res;
  logic                w_ovf;
  logic                w_illegal;
  logic                w_go_shift;
  logic [SHAMT_W-1:0]  w_shamt;
  logic [WIDTH-1:0]    w_shift_out;

  assign w_sum   = A + B;
  assign w_diff  = A - B;
  assign w_shamt = B[SHAMT_W-1:0];

`ifdef ALU_BARREL_SHIFT_EN
  alu_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
    .i_op    (ALUControl),
    .i_data  (A),
    .i_shamt (w_shamt),
    .o_data  (w_shift_out)
  );
  assign w_go_shift = 1'b0;
`else
  // Iterative mode: the shifter steps the working value held in r_result.
  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .i_op   (r_op),
    .i_data (r_result),
    .o_data (w_shift_out)
  );
  assign w_go_shift = is_shift(ALUControl) && (w_shamt != '0);
`endif

  always_comb begin
    w_res     = '0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    case (ALUControl)
      c_OP_AND: w_res = A & B;
      c_OP_OR:  w_res = A | B;
      c_OP_ADD: begin
        w_res = w_sum;
        w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_res = w_diff;
        w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      c_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
`ifdef ALU_BARREL_SHIFT_EN
      c_OP_SLL, c_OP_SRL, c_OP_SRA: w_res = w_shift_out;
`else
      // Seed value for the iterative shift; also the answer when shamt is 0.
      c_OP_SLL, c_OP_SRL, c_OP_SRA: w_res = A;
`endif
      default:  w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_illegal   <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      r_op        <= 4'b0000;
      r_cnt       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (InValid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_result   <= w_res;
            r_ovf      <= w_ovf;
            r_illegal  <= w_illegal;
`ifndef ALU_BARREL_SHIFT_EN
            r_op       <= ALUControl;
            r_cnt      <= w_shamt;
`endif
            if (w_go_shift) begin
              r_state <= S_SHIFT;
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_zero      <= (w_res == '0);
            end
          end
        end
`ifndef ALU_BARREL_SHIFT_EN
        S_SHIFT: begin
          r_result <= w_shift_out;
          r_cnt    <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_zero      <= (w_shift_out == '0);
          end
        end
`endif
        S_DONE: begin
          if (OutReady) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign InReady   = r_in_ready;
  assign OutValid  = r_out_valid;
  assign Result    = r_result;
  assign Zero      = r_zero;
  assign Overflow  = r_ovf;
  assign IllegalOp = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Scoreboard bench for alu_exec_unit with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit c_BARREL = 1'b1;
`else
  localparam bit c_BARREL = 1'b0;
`endif

  localparam logic [3:0] c_AND = 4'b0000, c_ADD = 4'b0001, c_SUB = 4'b0010;
  localparam logic [3:0] c_OR  = 4'b0011, c_SLL = 4'b0101, c_SRL = 4'b0110;
  localparam logic [3:0] c_SRA = 4'b1000, c_SLT = 4'b1001;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        InValid;
  logic        InReady;
  logic [3:0]  ALUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Result;
  logic        Zero;
  logic        Overflow;
  logic        IllegalOp;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic        il;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .InValid    (InValid),
    .InReady    (InReady),
    .ALUControl (ALUControl),
    .A          (A),
    .B          (B),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .Result     (Result),
    .Zero       (Zero),
    .Overflow   (Overflow),
    .IllegalOp  (IllegalOp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
  endtask

  function automatic int shift_lat(input int shamt);
    if (c_BARREL || shamt == 0) return 1;
    return shamt + 1;
  endfunction

  // Monitor: latency at first OutValid, field compare at each handshake.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge Clk);
      #1;
      if (OutValid) begin
        if (sb.size() == 0) begin
          if (!prev) check("unexpected_output", {31'b0, OutValid}, 32'd0);
        end else begin
          if (!prev) check("latency", cyc - sb[0].acc, sb[0].lat);
          if (OutReady) begin
            e = sb.pop_front();
            check("result",   Result, e.res);
            check("zero",     {31'b0, Zero}, {31'b0, e.z});
            check("overflow", {31'b0, Overflow}, {31'b0, e.ov});
            check("illegal",  {31'b0, IllegalOp}, {31'b0, e.il});
          end
        end
      end
      prev = OutValid;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic z, input logic ov, input logic il,
                       input int lat, input bit push);
    int   k;
    exp_t e;
    @(negedge Clk);
    InValid = 1'b1; ALUControl = op; A = a; B = b;
    k = 0;
    while (!InReady && k < 200) begin
      @(negedge Clk);
      k++;
    end
    if (!InReady) begin
      check("accept_timeout", {31'b0, InReady}, 32'd1);
      InValid = 1'b0;
    end else begin
      e.res = res; e.z = z; e.ov = ov; e.il = il; e.lat = lat; e.acc = cyc;
      if (push) sb.push_back(e);
      @(negedge Clk);
      InValid = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge Clk);
      k++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stimulus
    int k;
    Reset_n = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    ALUControl = 4'b0000; A = '0; B = '0;
    #3;
    check("rst_inready",  {31'b0, InReady},   32'd0);
    check("rst_outvalid", {31'b0, OutValid},  32'd0);
    check("rst_result",   Result,             32'd0);
    check("rst_zero",     {31'b0, Zero},      32'd0);
    check("rst_overflow", {31'b0, Overflow},  32'd0);
    check("rst_illegal",  {31'b0, IllegalOp}, 32'd0);
    @(negedge Clk); @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("inready_after_release", {31'b0, InReady}, 32'd1);

    //    op     A             B             Result        Z     OV    IL    latency
    issue(c_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1, 1);
    issue(c_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1, 1);
    issue(c_SLT, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1, 1);
    issue(c_SLL, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1'b0, shift_lat(31), 1);
    issue(c_SRA, 32'hF0000000, 32'h00000004, 32'hFF000000, 1'b0, 1'b0, 1'b0, shift_lat(4), 1);
    issue(c_SRL, 32'hF0000000, 32'h00000004, 32'h0F000000, 1'b0, 1'b0, 1'b0, shift_lat(4), 1);
    issue(c_SLL, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 1'b0, shift_lat(0), 1);
    issue(4'b0111, 32'h00000001, 32'h00000002, 32'h00000000, 1'b1, 1'b0, 1'b1, 1, 1);
    issue(4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1, 1, 1);
    issue(c_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1, 1);
    issue(c_OR,  32'h0F0F0F0F, 32'hF0F0F0F0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1, 1);
    issue(c_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1, 1);
    issue(c_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1, 1);
    issue(c_SLT, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1, 1);
    issue(c_SRA, 32'h80000000, 32'h00000021, 32'hC0000000, 1'b0, 1'b0, 1'b0, shift_lat(1), 1);
    issue(c_SRL, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 1'b0, shift_lat(31), 1);
    drain();

    // Consumer stalls: outputs must hold and new requests must be ignored.
    OutReady = 1'b0;
    issue(c_ADD, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0, 1, 1);
    k = 0;
    while (!OutValid && k < 50) begin
      @(negedge Clk);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      InValid = 1'b1; ALUControl = c_SUB; A = 32'd100; B = 32'd100;
      #1;
      check("hold_result",   Result, 32'h00000005);
      check("hold_outvalid", {31'b0, OutValid}, 32'd1);
      check("hold_inready",  {31'b0, InReady},  32'd0);
      @(negedge Clk);
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    drain();
    repeat (3) @(negedge Clk);

    // Reset in the middle of an operation discards it.
    issue(c_SLL, 32'h00000003, 32'h00000014, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("midop_rst_outvalid", {31'b0, OutValid}, 32'd0);
    check("midop_rst_inready",  {31'b0, InReady},  32'd0);
    check("midop_rst_result",   Result,            32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("midop_post_inready", {31'b0, InReady}, 32'd1);
    repeat (30) @(negedge Clk);

    issue(c_AND, 32'h0000FFFF, 32'h00FF00FF, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1, 1);
    drain();
    repeat (3) @(negedge Clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
